// File: rtl/mmio_csr_seq_if.sv
// AXI-lite style MMIO master bundle (AW/W/B/AR/R) driven by mmio_csr_seq.
// Master drives valids/addresses/data; slave drives readies and responses.
interface mmio_csr_seq_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 64,
  parameter int ID_W   = 9
);
  logic                  awvalid;
  logic                  awready;
  logic [ID_W-1:0]       awid;
  logic [ADDR_W-1:0]     awaddr;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ID_W-1:0]       arid;
  logic [ADDR_W-1:0]     araddr;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_W-1:0]     rdata;
  logic [1:0]            rresp;

  modport master (
    output awvalid, awid, awaddr, wvalid, wdata, wstrb, bready,
           arvalid, arid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awid, awaddr, wvalid, wdata, wstrb, bready,
           arvalid, arid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/mmio_csr_seq.sv
// Table-driven MMIO sequencer: replays WR / RD-compare entries over AXI and tallies errors; 2 cycles start-to-first-valid.
// Stalls indefinitely on AXI ready/valid unless MMIO_CSR_SEQ_TIMEOUT_EN enables the per-transaction watchdog.
module mmio_csr_seq #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 64,
  parameter int ID_W        = 9,
  parameter int DEPTH       = 16,
  parameter int TIMEOUT_CYC = 1024,
  localparam int IDX_W      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [15:0]        err_cnt,
  output logic [IDX_W-1:0]   fail_idx,
  output logic               timeout,
  input  logic               cmd_we,
  input  logic [IDX_W-1:0]   cmd_idx,
  input  logic [1:0]         cmd_op,
  input  logic [ADDR_W-1:0]  cmd_addr,
  input  logic [DATA_W-1:0]  cmd_data,
  input  logic [DATA_W-1:0]  cmd_mask,
  mmio_csr_seq_if.master     m
);

  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_WR  = 2'd1;
  localparam logic [1:0] OP_RD  = 2'd2;
  localparam logic [1:0] OP_END = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WR, S_WB, S_RA, S_RD, S_DONE
  } state_t;

  typedef struct packed {
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] mask;
  } entry_t;

  entry_t           tbl [DEPTH];
  entry_t           cur;
  state_t           state, nxt;
  logic [IDX_W-1:0] idx;
  logic             last;
  logic             aw_ok, w_ok;
  logic             aw_hs, w_hs, ar_hs;
  logic             rd_bad, err_ev, adv, to_ev;

  // Table has no reset so a run can be repeated after rst without reloading.
  always_ff @(posedge clk) begin
    if (cmd_we && state == S_IDLE) begin
      tbl[cmd_idx] <= '{op: cmd_op, addr: cmd_addr, data: cmd_data, mask: cmd_mask};
    end
  end

  assign cur    = tbl[idx];
  assign last   = &idx;
  assign aw_hs  = (state == S_WR) && !aw_ok && m.awready;
  assign w_hs   = (state == S_WR) && !w_ok  && m.wready;
  assign ar_hs  = (state == S_RA) && m.arready;
  assign rd_bad = ((m.rdata & cur.mask) != (cur.data & cur.mask)) || (m.rresp != 2'b00);
  assign err_ev = to_ev
                || ((state == S_WB) && m.bvalid && (m.bresp != 2'b00))
                || ((state == S_RD) && m.rvalid && rd_bad);
  assign adv    = !to_ev && (((state == S_FETCH) && (cur.op == OP_NOP))
                || ((state == S_WB) && m.bvalid)
                || ((state == S_RD) && m.rvalid));

`ifdef MMIO_CSR_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            active;

  assign active = (state == S_WR) || (state == S_WB) || (state == S_RA) || (state == S_RD);
  assign to_ev  = active && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  // Watchdog restarts for every transaction (FETCH sits between them).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (active) begin
      wd_cnt <= wd_cnt + 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout <= 1'b0;
    end else if (state == S_IDLE && start) begin
      timeout <= 1'b0;
    end else if (to_ev) begin
      timeout <= 1'b1;
    end
  end
`else
  assign to_ev   = (TIMEOUT_CYC < 0);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (start) nxt = S_FETCH;
      S_FETCH: begin
        case (cur.op)
          OP_NOP:  nxt = last ? S_DONE : S_FETCH;
          OP_WR:   nxt = S_WR;
          OP_RD:   nxt = S_RA;
          default: nxt = S_DONE;
        endcase
      end
      S_WR: begin
        if (to_ev)                                     nxt = S_DONE;
        else if ((aw_ok || aw_hs) && (w_ok || w_hs))   nxt = S_WB;
      end
      S_WB: begin
        if (to_ev)         nxt = S_DONE;
        else if (m.bvalid) nxt = last ? S_DONE : S_FETCH;
      end
      S_RA: begin
        if (to_ev)      nxt = S_DONE;
        else if (ar_hs) nxt = S_RD;
      end
      S_RD: begin
        if (to_ev)         nxt = S_DONE;
        else if (m.rvalid) nxt = last ? S_DONE : S_FETCH;
      end
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    m.awvalid = (state == S_WR) && !aw_ok;
    m.wvalid  = (state == S_WR) && !w_ok;
    m.bready  = (state == S_WB);
    m.arvalid = (state == S_RA);
    m.rready  = (state == S_RD);
    m.awid    = {ID_W{1'b0}};
    m.arid    = {ID_W{1'b0}};
    m.awaddr  = cur.addr;
    m.araddr  = cur.addr;
    m.wdata   = cur.data;
    m.wstrb   = {(DATA_W/8){1'b1}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      err_cnt  <= '0;
      fail_idx <= '1;
      pass     <= 1'b0;
      aw_ok    <= 1'b0;
      w_ok     <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        idx      <= '0;
        err_cnt  <= '0;
        fail_idx <= '1;
        pass     <= 1'b0;
      end
      if (state == S_FETCH) begin
        aw_ok <= 1'b0;
        w_ok  <= 1'b0;
      end
      if (aw_hs) aw_ok <= 1'b1;
      if (w_hs)  w_ok  <= 1'b1;
      if (adv && !last) idx <= idx + 1'b1;
      // err_cnt is zero only until the first error of the run, so it doubles as the first-error flag.
      if (err_ev) begin
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        if (err_cnt == 16'd0)    fail_idx <= idx;
      end
      if (state == S_DONE) pass <= (err_cnt == 16'd0) && !timeout;
    end
  end

endmodule

// File: tb/tb_mmio_csr_seq.sv
// Bench for mmio_csr_seq: vector table, directed multi-cycle sequences and randomized tables checked against a loop-level model.
module tb_mmio_csr_seq;
  localparam int ADDR_W = 20, DATA_W = 64, ID_W = 9, DEPTH = 16, TIMEOUT_CYC = 1024, IDX_W = 4;
  localparam logic [1:0] NOP = 2'd0, WR = 2'd1, RD = 2'd2, ENDC = 2'd3;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start, busy, done, pass, timeout, cmd_we;
  logic [15:0]       err_cnt;
  logic [IDX_W-1:0]  fail_idx, cmd_idx;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data, cmd_mask;

  mmio_csr_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) ifc ();

  mmio_csr_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .DEPTH(DEPTH),
                 .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_idx(fail_idx), .timeout(timeout), .cmd_we(cmd_we),
    .cmd_idx(cmd_idx), .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cmd_mask(cmd_mask), .m(ifc.master)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- slave model knobs (written only by the main initial) ----------------
  bit                rnd_rdy = 0, bad_en = 0, frc_en = 0;
  int                aw_lat = 0, w_lat = 0, ar_lat = 0;
  logic [ADDR_W-1:0] bad_addr = '0;
  logic [63:0]       frc_val = '0;

  // handshake counters (written only at posedge)
  int                aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
  logic [ADDR_W-1:0] wa_last, ra_last;
  logic [63:0]       wd_last;

  // slave-side state (written only at negedge)
  logic [63:0]       smem [int];
  int                aw_wait = 0, w_wait = 0, ar_wait = 0;
  int                wr_seen = 0, rd_seen = 0, bh_seen = 0, rh_seen = 0;

  always @(posedge clk) begin
    if (!rst) begin
      if (ifc.awvalid && ifc.awready) begin aw_hs++; wa_last = ifc.awaddr; end
      if (ifc.wvalid && ifc.wready)   begin w_hs++;  wd_last = ifc.wdata;  end
      if (ifc.bvalid && ifc.bready)   b_hs++;
      if (ifc.arvalid && ifc.arready) begin ar_hs++; ra_last = ifc.araddr; end
      if (ifc.rvalid && ifc.rready)   r_hs++;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      ifc.awready = 1'b0; ifc.wready = 1'b0; ifc.arready = 1'b0;
      ifc.bvalid = 1'b0; ifc.rvalid = 1'b0; ifc.bresp = 2'b00; ifc.rresp = 2'b00; ifc.rdata = '0;
      aw_wait = 0; w_wait = 0; ar_wait = 0;
      wr_seen = (aw_hs > w_hs) ? aw_hs : w_hs;
      rd_seen = ar_hs; bh_seen = b_hs; rh_seen = r_hs;
    end else begin
      if (ifc.awvalid) begin
        ifc.awready = rnd_rdy ? 1'($urandom_range(0, 1)) : (aw_wait >= aw_lat); aw_wait++;
      end else begin ifc.awready = 1'b0; aw_wait = 0; end
      if (ifc.wvalid) begin
        ifc.wready = rnd_rdy ? 1'($urandom_range(0, 1)) : (w_wait >= w_lat); w_wait++;
      end else begin ifc.wready = 1'b0; w_wait = 0; end
      if (ifc.arvalid) begin
        ifc.arready = rnd_rdy ? 1'($urandom_range(0, 1)) : (ar_wait >= ar_lat); ar_wait++;
      end else begin ifc.arready = 1'b0; ar_wait = 0; end

      if (ifc.bvalid) begin
        if (b_hs != bh_seen) begin ifc.bvalid = 1'b0; bh_seen = b_hs; end
      end else if (((aw_hs < w_hs) ? aw_hs : w_hs) > wr_seen && (!rnd_rdy || $urandom_range(0, 1) == 1)) begin
        wr_seen++;
        smem[int'(wa_last)] = wd_last;
        ifc.bresp  = (bad_en && wa_last == bad_addr) ? 2'b10 : 2'b00;
        ifc.bvalid = 1'b1;
      end

      if (ifc.rvalid) begin
        if (r_hs != rh_seen) begin ifc.rvalid = 1'b0; rh_seen = r_hs; end
      end else if (ar_hs > rd_seen && (!rnd_rdy || $urandom_range(0, 1) == 1)) begin
        rd_seen++;
        ifc.rdata  = frc_en ? frc_val : (smem.exists(int'(ra_last)) ? smem[int'(ra_last)] : 64'h0);
        ifc.rresp  = (bad_en && ra_last == bad_addr) ? 2'b10 : 2'b00;
        ifc.rvalid = 1'b1;
      end
    end
  end

  // ---------------- command table shadow and reference model ----------------
  typedef struct packed {
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [63:0]       data;
    logic [63:0]       mask;
  } ent_t;
  ent_t tab [DEPTH];

  task automatic put(input int i, input logic [1:0] op, input logic [ADDR_W-1:0] a,
                     input logic [63:0] d, input logic [63:0] mk);
    @(negedge clk);
    cmd_we = 1'b1; cmd_idx = IDX_W'(i); cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = mk;
    tab[i] = '{op: op, addr: a, data: d, mask: mk};
    @(negedge clk);
    cmd_we = 1'b0;
  endtask

  // Walks the table as the sequencer should, with the slave's memory and error injection.
  task automatic model(output int e_err, output logic [IDX_W-1:0] e_fidx, output int n_wr, output int n_rd);
    logic [63:0] mm [int];
    mm = smem;
    e_err = 0; e_fidx = '1; n_wr = 0; n_rd = 0;
    for (int i = 0; i < DEPTH; i++) begin
      bit bad;
      logic [63:0] rv;
      bad = 1'b0;
      if (tab[i].op == ENDC) break;
      if (tab[i].op == WR) begin
        mm[int'(tab[i].addr)] = tab[i].data;
        n_wr++;
        bad = bad_en && (tab[i].addr == bad_addr);
      end else if (tab[i].op == RD) begin
        rv = frc_en ? frc_val : (mm.exists(int'(tab[i].addr)) ? mm[int'(tab[i].addr)] : 64'h0);
        n_rd++;
        bad = ((rv & tab[i].mask) != (tab[i].data & tab[i].mask)) || (bad_en && tab[i].addr == bad_addr);
      end
      if (bad) begin
        if (e_err == 0) e_fidx = IDX_W'(i);
        if (e_err < 65535) e_err++;
      end
    end
  endtask

  task automatic run(output int cyc, output int first);
    bit seen;
    seen = 0; cyc = 0; first = -1;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (first < 0 && (ifc.awvalid || ifc.arvalid)) first = cyc;
      if (done) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL run_done: no done pulse within %0d cycles, required one", cyc);
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic run_chk(input string tag, input int exp_first);
    int e_err, n_wr, n_rd, cyc, first, aw0, ar0;
    logic [IDX_W-1:0] e_f;
    model(e_err, e_f, n_wr, n_rd);
    aw0 = aw_hs; ar0 = ar_hs;
    run(cyc, first);
    chk({tag, " err_cnt"}, err_cnt, e_err);
    chk({tag, " fail_idx"}, fail_idx, e_f);
    chk({tag, " pass"}, pass, e_err == 0);
    chk({tag, " aw_count"}, aw_hs - aw0, n_wr);
    chk({tag, " ar_count"}, ar_hs - ar0, n_rd);
    chk({tag, " idle"}, {done, busy}, 2'b00);
`ifndef MMIO_CSR_SEQ_TIMEOUT_EN
    chk({tag, " timeout"}, timeout, 1'b0);
`endif
    if (exp_first > 0) chk({tag, " latency"}, first, exp_first);
  endtask

  typedef struct {
    logic [1:0]        op;
    logic [63:0]       data;
    logic [63:0]       mask;
    logic [63:0]       frc;
    bit                inj;
    int                exp_err;
    bit                exp_pass;
    logic [IDX_W-1:0]  exp_fidx;
  } vec_t;

  initial begin
    vec_t vt [11];
    int   cyc, first, aw0, ar0, w0, b0;

    vt[0]  = '{RD, 64'hFF, 64'h0F, 64'hAF, 0, 0, 1, 4'hF};
    vt[1]  = '{RD, 64'hFF, 64'hFF, 64'hAF, 0, 1, 0, 4'h0};
    vt[2]  = '{RD, 64'h0,  64'h0,  64'hDEAD, 0, 0, 1, 4'hF};
    vt[3]  = '{RD, ONES,   ONES,   ONES, 0, 0, 1, 4'hF};
    vt[4]  = '{RD, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 0, 1, 0, 4'h0};
    vt[5]  = '{RD, 64'h0,  64'h0,  64'h0, 1, 1, 0, 4'h0};
    vt[6]  = '{WR, 64'h5,  64'h0,  64'h0, 0, 0, 1, 4'hF};
    vt[7]  = '{WR, 64'h5,  64'h0,  64'h0, 1, 1, 0, 4'h0};
    vt[8]  = '{NOP, 64'h0, 64'h0,  64'h0, 0, 0, 1, 4'hF};
    vt[9]  = '{ENDC, 64'h0, 64'h0, 64'h0, 0, 0, 1, 4'hF};
    vt[10] = '{RD, 64'hFF, 64'hFF, 64'hAF, 1, 1, 0, 4'h0};

    rst = 1'b1; start = 1'b0; cmd_we = 1'b0; cmd_idx = '0; cmd_op = '0;
    cmd_addr = '0; cmd_data = '0; cmd_mask = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst pass", pass, 1'b0);
    chk("rst err_cnt", err_cnt, 16'h0);
    chk("rst fail_idx", fail_idx, 4'hF);
    chk("rst timeout", timeout, 1'b0);
    chk("rst valids", {ifc.awvalid, ifc.wvalid, ifc.arvalid, ifc.bready, ifc.rready}, 5'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst busy", busy, 1'b0);

    // echo write then read back
    put(0, WR, 20'h0, 64'h1234, 64'h0);
    put(1, RD, 20'h0, 64'h1234, ONES);
    put(2, ENDC, 20'h0, 64'h0, 64'h0);
    run_chk("echo", 2);
    chk("echo pass const", pass, 1'b1);
    chk("echo err const", err_cnt, 16'h0);

    // single-entry vector table
    for (int v = 0; v < 11; v++) begin
      put(0, vt[v].op, 20'h10, vt[v].data, vt[v].mask);
      put(1, ENDC, 20'h0, 64'h0, 64'h0);
      frc_en = 1; frc_val = vt[v].frc; bad_en = vt[v].inj; bad_addr = 20'h10;
      run(cyc, first);
      chk($sformatf("vec%0d err_cnt", v), err_cnt, vt[v].exp_err);
      chk($sformatf("vec%0d pass", v), pass, vt[v].exp_pass);
      chk($sformatf("vec%0d fail_idx", v), fail_idx, vt[v].exp_fidx);
    end
    frc_en = 0; bad_en = 0;

    // AW and W accepted at different times
    for (int s = 0; s < 2; s++) begin
      put(0, WR, 20'h30, 64'hCAFE, 64'h0);
      put(1, ENDC, 20'h0, 64'h0, 64'h0);
      aw_lat = (s == 0) ? 3 : 0; w_lat = (s == 0) ? 0 : 3;
      aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
      run(cyc, first);
      chk($sformatf("skew%0d aw_hs", s), aw_hs - aw0, 1);
      chk($sformatf("skew%0d w_hs", s), w_hs - w0, 1);
      chk($sformatf("skew%0d b_hs", s), b_hs - b0, 1);
      chk($sformatf("skew%0d pass", s), pass, 1'b1);
    end
    aw_lat = 0; w_lat = 0;

    // bad bresp on entry 3, data mismatch on entry 5
    put(0, WR, 20'h40, 64'h1111, 64'h0);
    put(1, RD, 20'h40, 64'h1111, ONES);
    put(2, NOP, 20'h0, 64'h0, 64'h0);
    put(3, WR, 20'h44, 64'h3333, 64'h0);
    put(4, NOP, 20'h0, 64'h0, 64'h0);
    put(5, RD, 20'h40, 64'h2222, ONES);
    put(6, ENDC, 20'h0, 64'h0, 64'h0);
    bad_en = 1; bad_addr = 20'h44;
    run_chk("two_err", 2);
    chk("two_err err_cnt const", err_cnt, 16'd2);
    chk("two_err fail_idx const", fail_idx, 4'd3);
    bad_en = 0;

    // END at index 2; a table write while busy must be dropped
    put(0, WR, 20'h50, 64'h77, 64'h0);
    put(1, RD, 20'h50, 64'h77, ONES);
    put(2, ENDC, 20'h0, 64'h0, 64'h0);
    put(3, WR, 20'h54, 64'h99, 64'h0);
    aw0 = aw_hs; ar0 = ar_hs;
    fork
      run(cyc, first);
      begin
        repeat (3) @(negedge clk);
        cmd_we = 1'b1; cmd_idx = 4'd2; cmd_op = NOP; cmd_addr = '0; cmd_data = '0; cmd_mask = '0;
        @(negedge clk);
        cmd_we = 1'b0;
      end
    join
    chk("end2 txn count", (aw_hs - aw0) + (ar_hs - ar0), 2);
    chk("end2 pass", pass, 1'b1);
    aw0 = aw_hs; ar0 = ar_hs;
    run_chk("end2_rerun", 0);
    chk("end2 rerun txn count", (aw_hs - aw0) + (ar_hs - ar0), 2);

    // last entry completes the run without wrap-around
    for (int i = 0; i < DEPTH - 1; i++) put(i, NOP, 20'h0, 64'h0, 64'h0);
    put(DEPTH - 1, WR, 20'h60, 64'hABC, 64'h0);
    aw0 = aw_hs;
    run_chk("last_entry", 0);
    chk("last_entry aw const", aw_hs - aw0, 1);

`ifdef MMIO_CSR_SEQ_TIMEOUT_EN
    put(0, RD, 20'h70, 64'h0, 64'h0);
    put(1, ENDC, 20'h0, 64'h0, 64'h0);
    ar_lat = 100000;
    run(cyc, first);
    chk("wdog timeout", timeout, 1'b1);
    chk("wdog err_cnt", err_cnt, 16'd1);
    chk("wdog pass", pass, 1'b0);
    chk("wdog fail_idx", fail_idx, 4'd0);
    chk("wdog cycles", cyc, 2 + TIMEOUT_CYC);
    ar_lat = 0;
`endif

    // reset while a read address is outstanding
    put(0, RD, 20'h70, 64'h0, 64'h0);
    put(1, ENDC, 20'h0, 64'h0, 64'h0);
    ar_lat = 100000;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20 && !ifc.arvalid; k++) @(negedge clk);
    chk("rst_mid arvalid before", ifc.arvalid, 1'b1);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid arvalid", ifc.arvalid, 1'b0);
    chk("rst_mid busy", busy, 1'b0);
    chk("rst_mid fail_idx", fail_idx, 4'hF);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ar_lat = 0;
    run_chk("after_rst", 2);

    // randomized tables and ready/valid timing
    rnd_rdy = 1;
    for (int t = 0; t < 20; t++) begin
      bad_en = ($urandom_range(0, 2) == 0);
      bad_addr = ADDR_W'(8 * $urandom_range(0, 3));
      for (int i = 0; i < DEPTH; i++) begin
        int r, mk;
        logic [1:0] op;
        logic [63:0] msk;
        r  = $urandom_range(0, 9);
        op = (r < 2) ? NOP : (r < 5) ? WR : (r < 9) ? RD : ENDC;
        mk = $urandom_range(0, 2);
        msk = (mk == 0) ? 64'h0 : (mk == 1) ? ONES : {$urandom, $urandom};
        put(i, op, ADDR_W'(8 * $urandom_range(0, 3)), 64'($urandom_range(0, 3)), msk);
      end
      run_chk($sformatf("rand%0d", t), 0);
    end
    rnd_rdy = 0; bad_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule

// File: doc/mmio_csr_seq.md
MMIO_CSR_SEQ -- requirements
Module: mmio_csr_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, AXI MMIO address width.
REQ-002 SHALL have parameter DATA_W, default 64, AXI MMIO data width (32 or 64).
REQ-003 SHALL have parameter ID_W, default 9, AXI ID width.
REQ-004 SHALL have parameter DEPTH, default 16, command-table entries (power of 2, 2..256).
REQ-005 SHALL have parameter TIMEOUT_CYC, default 1024, response watchdog limit in cycles.
REQ-006 SHALL have port clk  in  1  single clock for all logic.
REQ-007 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port start  in  1  run pulse.
REQ-009 SHALL have port busy  out  1  run in progress.
REQ-010 SHALL have port done  out  1  one-cycle end-of-run pulse.
REQ-011 SHALL have port pass  out  1  last run had zero errors.
REQ-012 SHALL have port err_cnt  out  16  errors in last run.
REQ-013 SHALL have port fail_idx  out  log2(DEPTH)  index of first failing entry.
REQ-014 SHALL have port timeout  out  1  last run aborted by watchdog.
REQ-015 SHALL have port cmd_we  in  1  table write strobe.
REQ-016 SHALL have port cmd_idx  in  log2(DEPTH)  table write index.
REQ-017 SHALL have port cmd_op  in  2  0=NOP, 1=WR, 2=RD-compare, 3=END.
REQ-018 SHALL have port cmd_addr  in  ADDR_W  target address.
REQ-019 SHALL have port cmd_data  in  DATA_W  write data or expected read data.
REQ-020 SHALL have port cmd_mask  in  DATA_W  compare mask for RD.
REQ-021 SHALL have AXI master channels AW (awvalid/awready/awid/awaddr), W (wvalid/wready/wdata/wstrb), B (bvalid/bready/bresp), AR (arvalid/arready/arid/araddr), R (rvalid/rready/rdata/rresp); widths per parameters.

Function
REQ-022 SHALL use states IDLE, FETCH, WR, WB, RA, RD, DONE.
REQ-023 SHALL on start in IDLE clear err_cnt, timeout, fail_idx (to all-ones), set index 0, and go to FETCH; start SHALL be ignored outside IDLE.
REQ-024 SHALL accept cmd_we only in IDLE; writes while busy SHALL be dropped.
REQ-025 SHALL in FETCH decode the entry: NOP advances the index in one cycle; WR goes to WR; RD goes to RA; END goes to DONE.
REQ-026 SHALL in WR assert awvalid and wvalid together, dropping each independently after its own handshake, and enter WB once both have handshaken.
REQ-027 SHALL hold bready=1 in WB and count an error when bvalid with bresp!=0.
REQ-028 SHALL in RA hold arvalid until arready, then hold rready=1 in RD.
REQ-029 SHALL in RD count one error when (rdata & mask) != (data & mask) or rresp!=0.
REQ-030 SHALL drive awid=arid=0, wstrb all ones, and keep address, data, and valid stable while a valid is not yet accepted.
REQ-031 SHALL record fail_idx only on the first error of a run.
REQ-032 SHALL saturate err_cnt at 16'hFFFF.
REQ-033 SHALL go to DONE after the entry at index DEPTH-1 completes, with no wrap-around.
REQ-034 SHALL in DONE pulse done for one cycle, set pass = (err_cnt==0 and !timeout), and return to IDLE; pass, err_cnt, fail_idx, and timeout SHALL hold until the next start.
REQ-035 SHALL assert busy in every state except IDLE.
REQ-036 SHALL have a start-to-first-awvalid/arvalid latency of 2 cycles.

Reset
REQ-037 SHALL on rst force IDLE, with all valids/readies, busy, done, pass, err_cnt, and timeout at 0 and fail_idx at all-ones; the table contents SHALL be preserved.
REQ-038 SHALL on rst mid-transaction drop all valids immediately and issue no retry.

Configuration
REQ-039 SHALL with MMIO_CSR_SEQ_TIMEOUT_EN defined count cycles spent in WR/WB/RA/RD; on reaching TIMEOUT_CYC it SHALL drop valids, set timeout, increment err_cnt, and go to DONE.
REQ-040 SHALL without MMIO_CSR_SEQ_TIMEOUT_EN tie timeout to 0 and wait indefinitely.

Verification
REQ-041 SHALL be verified by: WR 0x0 data 0x1234 then RD 0x0 mask all-ones expect 0x1234, with the slave echoing -> done, pass=1, err_cnt=0.
REQ-042 SHALL be verified by: RD expecting 0xFF with mask 0x0F while the slave returns 0xAF -> pass=1; the same entry with mask 0xFF -> err_cnt=1, fail_idx=0.
REQ-043 SHALL be verified by: awready delayed 3 cycles after wready, and vice versa -> exactly one AW and one W handshake, then B accepted.
REQ-044 SHALL be verified by: bresp=2'b10 on entry 3 and a mismatch on entry 5 -> err_cnt=2, fail_idx=3.
REQ-045 SHALL be verified by: END at index 2 -> done asserted after 2 transactions; cmd_we issued while busy leaves the table unchanged.
REQ-046 SHALL be verified by: arready held low with the macro defined -> timeout=1 and done at 1024 cycles; rst asserted mid-RD -> arvalid=0 on the next edge.
